// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizer, start qualification, mid-bit sampling, frame decode.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote at every sample point.
module uart_rx_engine #(
  parameter int CLK_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       rx_clr,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam int HALF = CLK_PER_BIT / 2;
  localparam int TW   = $clog2(CLK_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    sr_q, sr_d;
  logic          eight_q, eight_d;
  logic          pen_q, pen_d;
  logic          ohel_q, ohel_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic          s1_q, rxs_q;
  logic          samp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      s1_q  <= rx;
      rxs_q <= s1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic h1_q, h2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h1_q <= 1'b1;
      h2_q <= 1'b1;
    end else begin
      h1_q <= rxs_q;
      h2_q <= h1_q;
    end
  end

  assign samp = (rxs_q & h1_q) | (rxs_q & h2_q) | (h1_q & h2_q);
`else
  assign samp = rxs_q;
`endif

  // Frame length F counts start, data, parity and stop bits
  logic [3:0] flen;
  logic [3:0] stop_idx;
  logic [9:0] sr_n;
  logic [9:0] v;
  logic [7:0] dat;
  logic       pbit;
  logic       stop;
  logic       perr_n;
  logic       done;

  assign flen     = (eight_q ? 4'd10 : 4'd9) + {3'b000, pen_q};
  assign stop_idx = (eight_q ? 4'd8 : 4'd7) + {3'b000, pen_q};
  assign sr_n     = {samp, sr_q[9:1]};
  assign v        = sr_n >> (4'd11 - flen);
  assign dat      = eight_q ? v[7:0] : {1'b0, v[6:0]};
  assign pbit     = eight_q ? v[8] : v[7];
  assign stop     = v[stop_idx];
  assign perr_n   = pen_q & (pbit ^ (^dat) ^ ohel_q);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    eight_d = eight_q;
    pen_d   = pen_q;
    ohel_d  = ohel_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        cnt_d = 4'd0;
        if (!rxs_q) begin
          state_d = START;
          eight_d = eight;
          pen_d   = pen;
          ohel_d  = ohel;
        end
      end
      START: begin
        if (tmr_q == TW'(HALF - 1)) begin
          if (samp) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            tmr_d   = '0;
            cnt_d   = 4'd1;
          end
        end
      end
      DATA: begin
        if (tmr_q == TW'(CLK_PER_BIT - 1)) begin
          tmr_d = '0;
          sr_d  = sr_n;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == flen) begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion beats a simultaneous read; that read still consumes the old char
  always_comb begin
    data_d = data_q;
    rdy_d  = rdy_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ovf_d  = ovf_q;
    if (done) begin
      data_d = dat;
      rdy_d  = 1'b1;
      perr_d = perr_n;
      ferr_d = ~stop;
      ovf_d  = rx_clr ? 1'b0 : (ovf_q | rdy_q);
    end else if (rx_clr) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= 4'd0;
      sr_q    <= 10'd0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      data_q  <= 8'h00;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      eight_q <= eight_d;
      pen_q   <= pen_d;
      ohel_q  <= ohel_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rx_data = data_q;
  assign rx_rdy  = rdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule
